sync_fifo_ndeep: RTL and testbench
==================================

// Module: sync_fifo_ndeep
// PURPOSE
//   Single-clock circular-buffer FIFO: the same-domain sibling of the dual-clock CDC FIFO.
//   Generalised in width and depth, with selectable standard/first-word-fall-through read mode.
//   Adds fill-level output, programmable almost-full/almost-empty flags and sticky overflow/underflow flags.
//   Used for rate smoothing inside one clock domain, e.g. behind a CDC FIFO's read port.
// PARAMETERS
//   DATA_WIDTH          8  width of each stored word
//   BUFFER_DEPTH_POWER  2  capacity DEPTH = 2**BUFFER_DEPTH_POWER words (>=1)
//   FWFT                0  0: standard read (data 1 cycle after rd_en); 1: first-word-fall-through
//   AFULL_THRESH        3  almost_full_o = (level_o >= AFULL_THRESH); range 1..DEPTH
//   AEMPTY_THRESH       1  almost_empty_o = (level_o <= AEMPTY_THRESH); range 0..DEPTH-1
// PORTS
//   clk_i           in   1                     clock; all logic on rising edge
//   rst_i           in   1                     asynchronous, active-high reset
//   wr_en_i         in   1                     write request
//   wr_data_i       in   DATA_WIDTH            write data
//   wr_rdy_o        out  1                     FIFO not full; write accepted when wr_en_i & wr_rdy_o
//   rd_en_i         in   1                     read request (standard) / pop acknowledge (FWFT)
//   rd_rdy_o        out  1                     a word is available to read/pop
//   rd_data_o       out  DATA_WIDTH            read data, registered
//   rd_vld_o        out  1                     rd_data_o holds a valid word (see BEHAVIOUR)
//   level_o         out  BUFFER_DEPTH_POWER+1  words accepted and not yet read/popped (0..DEPTH)
//   almost_full_o   out  1                     level_o >= AFULL_THRESH
//   almost_empty_o  out  1                     level_o <= AEMPTY_THRESH
//   ovf_o           out  1                     sticky: write attempted while full
//   udf_o           out  1                     sticky: read attempted while empty
//   clr_err_i       in   1                     clears ovf_o/udf_o
// BEHAVIOUR
//   Reset (async assert, any cycle): pointers=0, level_o=0, rd_data_o=0, rd_vld_o=0, rd_rdy_o=0,
//     ovf_o=0, udf_o=0, wr_rdy_o=1, almost_full_o=0, almost_empty_o=1. Storage array is not reset.
//   Reset mid-operation discards all contents; the first post-reset write behaves as into an empty FIFO.
//   Pointers: BUFFER_DEPTH_POWER+1 bits (wrap bit). Empty: ptrs equal. Full: MSBs differ, rest equal.
//   Pointers wrap modulo 2*DEPTH; no other wrap handling.
//   Capacity is exactly DEPTH words in both modes; level_o includes any word held in the FWFT output register.
//   wr_rdy_o, rd_rdy_o and the almost flags derive from registered state only; no combinational in->out path.
//   Write accepted (acc_wr) = wr_en_i & wr_rdy_o. Data is stored and level_o increments on the next edge.
//   Standard mode (FWFT=0):
//     - rd_rdy_o = !empty. Read accepted (acc_rd) = rd_en_i & rd_rdy_o.
//     - Next edge: rd_data_o <= head word; rd_vld_o=1 for exactly that one cycle.
//     - rd_data_o holds its value otherwise.
//   FWFT mode (FWFT=1):
//     - rd_vld_o=1 while rd_data_o holds the head word; rd_rdy_o == rd_vld_o.
//     - Write into an empty FIFO: rd_vld_o rises 1 cycle after acceptance, showing that word.
//     - Pop (acc_rd) = rd_en_i & rd_vld_o. Next edge: next word is presented, or rd_vld_o=0 if none remain.
//     - Back-to-back pops drain at 1 word/cycle.
//   Simultaneous acc_wr & acc_rd: level_o unchanged. Both flags are judged on pre-edge state, so
//     full rejects the write and empty rejects the read even when the opposite op is in the same cycle.
//   Error flags:
//     - ovf_o sets on wr_en_i & !wr_rdy_o; udf_o sets on rd_en_i & !rd_rdy_o.
//     - Both cleared by clr_err_i; set wins over a simultaneous clear.
//     - A rejected op has no other effect.
// TESTING (DATA_WIDTH=8, BUFFER_DEPTH_POWER=2, AFULL_THRESH=3, AEMPTY_THRESH=1)
//   Reset: rst_i pulse -> wr_rdy_o=1, rd_rdy_o=0, level_o=0, almost_empty_o=1, ovf_o=udf_o=0, rd_data_o=0.
//   Fill/overflow: write 0x11,0x22,0x33,0x44,0x55 -> level_o 1..4, almost_full_o at level 3,
//     wr_rdy_o=0 at 4, 0x55 dropped, ovf_o=1; clr_err_i -> ovf_o=0.
//   Standard drain: FWFT=0, 4 reads from full -> rd_data_o 0x11,0x22,0x33,0x44, each 1 cycle after rd_en_i
//     with rd_vld_o pulse; 5th read -> udf_o=1, rd_data_o holds 0x44.
//   FWFT: FWFT=1, write 0xA5 into empty -> next cycle rd_vld_o=1, rd_data_o=0xA5 with no rd_en_i;
//     pop -> rd_vld_o=0, level_o=0.
//   Wrap + simultaneous: 10 cycles of concurrent write/read at level 2 -> level_o stays 2,
//     data order preserved across pointer wrap; full + wr&rd -> write rejected, ovf_o=1.
//   Async reset mid-burst: assert rst_i between edges at level 3 -> outputs take reset values immediately;
//     post-reset write 0x5A is the first word read.

Source files
------------

// File: rtl/sync_fifo_ndeep_if.sv
// rtl/sync_fifo_ndeep_if.sv - write/read/status bundle of the single-clock FIFO
interface sync_fifo_ndeep_if #(
   parameter int DATA_WIDTH         = 8,
   parameter int BUFFER_DEPTH_POWER = 2
);
   logic                          wr_en_i;
   logic [DATA_WIDTH-1:0]         wr_data_i;
   logic                          wr_rdy_o;
   logic                          rd_en_i;
   logic                          rd_rdy_o;
   logic [DATA_WIDTH-1:0]         rd_data_o;
   logic                          rd_vld_o;
   logic [BUFFER_DEPTH_POWER:0]   level_o;
   logic                          almost_full_o;
   logic                          almost_empty_o;
   logic                          ovf_o;
   logic                          udf_o;
   logic                          clr_err_i;

   modport master (
      output wr_en_i, wr_data_i, rd_en_i, clr_err_i,
      input  wr_rdy_o, rd_rdy_o, rd_data_o, rd_vld_o, level_o,
             almost_full_o, almost_empty_o, ovf_o, udf_o
   );

   modport slave (
      input  wr_en_i, wr_data_i, rd_en_i, clr_err_i,
      output wr_rdy_o, rd_rdy_o, rd_data_o, rd_vld_o, level_o,
             almost_full_o, almost_empty_o, ovf_o, udf_o
   );
endinterface

// File: rtl/sync_fifo_ndeep.sv
// rtl/sync_fifo_ndeep.sv - single-clock circular-buffer FIFO, standard or first-word-fall-through read
module sync_fifo_ndeep #(
   parameter int DATA_WIDTH         = 8,
   parameter int BUFFER_DEPTH_POWER = 2,
   parameter bit FWFT               = 1'b0,
   parameter int AFULL_THRESH       = 3,
   parameter int AEMPTY_THRESH      = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   sync_fifo_ndeep_if.slave  bus
);
   localparam int DEPTH = 2 ** BUFFER_DEPTH_POWER;
   localparam int PW    = BUFFER_DEPTH_POWER + 1;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_vld;
   logic                  r_ovf;
   logic                  r_udf;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_rd_rdy;
   logic                  w_acc_wr;
   logic                  w_acc_rd;
   logic [PW-1:0]         w_level;
   logic [PW-1:0]         w_wr_ptr_nxt;
   logic [PW-1:0]         w_rd_ptr_nxt;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_empty      = (r_wr_ptr == r_rd_ptr);
   assign w_full       = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                         (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
   assign w_level      = r_wr_ptr - r_rd_ptr;
   assign w_rd_rdy     = FWFT ? r_rd_vld : !w_empty;
   assign w_acc_wr     = bus.wr_en_i & !w_full;
   assign w_acc_rd     = bus.rd_en_i & w_rd_rdy;
   assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_acc_wr);
   assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_acc_rd);

   always_ff @(posedge clk_i) begin
      if (w_acc_wr) begin
         r_mem[r_wr_ptr[PW-2:0]] <= bus.wr_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // The head word stays in its memory slot while shown, so capacity remains DEPTH.
         logic w_avail_nxt;
         logic w_load;
         logic [DATA_WIDTH-1:0] w_head_nxt;

         assign w_avail_nxt = (w_wr_ptr_nxt != w_rd_ptr_nxt);
         assign w_load      = w_avail_nxt & (w_acc_rd | !r_rd_vld);
         assign w_head_nxt  = (w_rd_ptr_nxt == r_wr_ptr) ? bus.wr_data_i
                                                         : r_mem[w_rd_ptr_nxt[PW-2:0]];

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_rd_data <= '0;
               r_rd_vld  <= 1'b0;
            end else begin
               r_rd_vld <= w_avail_nxt;
               if (w_load) begin
                  r_rd_data <= w_head_nxt;
               end
            end
         end
      end else begin : g_std
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_rd_data <= '0;
               r_rd_vld  <= 1'b0;
            end else begin
               r_rd_vld <= w_acc_rd;
               if (w_acc_rd) begin
                  r_rd_data <= r_mem[r_rd_ptr[PW-2:0]];
               end
            end
         end
      end
   endgenerate

   // A new error in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (bus.wr_en_i & w_full) begin
            r_ovf <= 1'b1;
         end else if (bus.clr_err_i) begin
            r_ovf <= 1'b0;
         end
         if (bus.rd_en_i & !w_rd_rdy) begin
            r_udf <= 1'b1;
         end else if (bus.clr_err_i) begin
            r_udf <= 1'b0;
         end
      end
   end

   assign bus.wr_rdy_o       = !w_full;
   assign bus.rd_rdy_o       = w_rd_rdy;
   assign bus.rd_data_o      = r_rd_data;
   assign bus.rd_vld_o       = r_rd_vld;
   assign bus.level_o        = w_level;
   assign bus.almost_full_o  = (w_level >= PW'(AFULL_THRESH));
   assign bus.almost_empty_o = (w_level <= PW'(AEMPTY_THRESH));
   assign bus.ovf_o          = r_ovf;
   assign bus.udf_o          = r_udf;
endmodule

// File: tb/tb_sync_fifo_ndeep.sv
// tb/tb_sync_fifo_ndeep.sv - directed vector bench for standard and FWFT builds of sync_fifo_ndeep
module tb_sync_fifo_ndeep;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   typedef struct {
      logic       wr;
      logic [7:0] wdata;
      logic       rd;
      logic       clr;
      logic [2:0] lvl;
      logic       wrdy;
      logic       rrdy;
      logic       af;
      logic       ae;
      logic       ovf;
      logic       udf;
      logic       vld;
      logic       chk_data;
      logic [7:0] rdata;
   } vec_t;

   vec_t       tab[$];
   logic [7:0] model_q[$];
   logic [7:0] exp_d;

   sync_fifo_ndeep_if #(.DATA_WIDTH(8), .BUFFER_DEPTH_POWER(2)) s_if ();
   sync_fifo_ndeep_if #(.DATA_WIDTH(8), .BUFFER_DEPTH_POWER(2)) f_if ();

   sync_fifo_ndeep #(.DATA_WIDTH(8), .BUFFER_DEPTH_POWER(2), .FWFT(1'b0),
                     .AFULL_THRESH(3), .AEMPTY_THRESH(1))
      u_std (.clk_i(clk), .rst_i(rst), .bus(s_if.slave));

   sync_fifo_ndeep #(.DATA_WIDTH(8), .BUFFER_DEPTH_POWER(2), .FWFT(1'b1),
                     .AFULL_THRESH(3), .AEMPTY_THRESH(1))
      u_fwft (.clk_i(clk), .rst_i(rst), .bus(f_if.slave));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_s(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
      s_if.wr_en_i   = wr;
      s_if.wr_data_i = d;
      s_if.rd_en_i   = rd;
      s_if.clr_err_i = clr;
   endtask

   task automatic drv_f(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
      f_if.wr_en_i   = wr;
      f_if.wr_data_i = d;
      f_if.rd_en_i   = rd;
      f_if.clr_err_i = clr;
   endtask

   task automatic add(input logic wr, input logic [7:0] wd, input logic rd, input logic clr,
                      input logic [2:0] lvl, input logic wrdy, input logic rrdy,
                      input logic af, input logic ae, input logic ovf, input logic udf,
                      input logic vld, input logic chk_data, input logic [7:0] rdata);
      vec_t v;
      v.wr = wr; v.wdata = wd; v.rd = rd; v.clr = clr;
      v.lvl = lvl; v.wrdy = wrdy; v.rrdy = rrdy; v.af = af; v.ae = ae;
      v.ovf = ovf; v.udf = udf; v.vld = vld; v.chk_data = chk_data; v.rdata = rdata;
      tab.push_back(v);
   endtask

   initial begin
      drv_s(1'b0, 8'h00, 1'b0, 1'b0);
      drv_f(1'b0, 8'h00, 1'b0, 1'b0);

      // Standard-mode vectors: wr wd rd clr | lvl wrdy rrdy af ae ovf udf vld chk rdata
      add(1, 8'h11, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 8'h00);
      add(1, 8'h22, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00);
      add(1, 8'h33, 0, 0, 3, 1, 1, 1, 0, 0, 0, 0, 0, 8'h00);
      add(1, 8'h44, 0, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0, 8'h00);
      add(1, 8'h55, 0, 0, 4, 0, 1, 1, 0, 1, 0, 0, 0, 8'h00);
      add(0, 8'h00, 0, 1, 4, 0, 1, 1, 0, 0, 0, 0, 0, 8'h00);
      add(0, 8'h00, 1, 0, 3, 1, 1, 1, 0, 0, 0, 1, 1, 8'h11);
      add(0, 8'h00, 1, 0, 2, 1, 1, 0, 0, 0, 0, 1, 1, 8'h22);
      add(0, 8'h00, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 1, 8'h22);
      add(0, 8'h00, 1, 0, 1, 1, 1, 0, 1, 0, 0, 1, 1, 8'h33);
      add(0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 8'h44);
      add(0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 8'h44);
      add(0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 8'h44);
      add(0, 8'h00, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 8'h44);
      add(0, 8'h00, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 8'h44);
      add(0, 8'h00, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 8'h44);

      #1 rst = 1'b1;
      #2;
      chk("rst.std.wr_rdy", s_if.wr_rdy_o, 1);
      chk("rst.std.rd_rdy", s_if.rd_rdy_o, 0);
      chk("rst.std.level", s_if.level_o, 0);
      chk("rst.std.aempty", s_if.almost_empty_o, 1);
      chk("rst.std.afull", s_if.almost_full_o, 0);
      chk("rst.std.ovf", s_if.ovf_o, 0);
      chk("rst.std.udf", s_if.udf_o, 0);
      chk("rst.std.rd_data", s_if.rd_data_o, 0);
      chk("rst.std.rd_vld", s_if.rd_vld_o, 0);
      chk("rst.fwft.rd_vld", f_if.rd_vld_o, 0);
      chk("rst.fwft.rd_rdy", f_if.rd_rdy_o, 0);
      chk("rst.fwft.wr_rdy", f_if.wr_rdy_o, 1);
      cyc();
      cyc();
      rst = 1'b0;

      foreach (tab[i]) begin
         drv_s(tab[i].wr, tab[i].wdata, tab[i].rd, tab[i].clr);
         cyc();
         chk($sformatf("std[%0d].level", i), s_if.level_o, tab[i].lvl);
         chk($sformatf("std[%0d].wr_rdy", i), s_if.wr_rdy_o, tab[i].wrdy);
         chk($sformatf("std[%0d].rd_rdy", i), s_if.rd_rdy_o, tab[i].rrdy);
         chk($sformatf("std[%0d].afull", i), s_if.almost_full_o, tab[i].af);
         chk($sformatf("std[%0d].aempty", i), s_if.almost_empty_o, tab[i].ae);
         chk($sformatf("std[%0d].ovf", i), s_if.ovf_o, tab[i].ovf);
         chk($sformatf("std[%0d].udf", i), s_if.udf_o, tab[i].udf);
         chk($sformatf("std[%0d].rd_vld", i), s_if.rd_vld_o, tab[i].vld);
         if (tab[i].chk_data) begin
            chk($sformatf("std[%0d].rd_data", i), s_if.rd_data_o, tab[i].rdata);
         end
      end
      drv_s(1'b0, 8'h00, 1'b0, 1'b0);

      // Concurrent write/read at level 2 across pointer wrap.
      for (int k = 0; k < 2; k++) begin
         drv_s(1'b1, 8'h60 + 8'(k), 1'b0, 1'b0);
         model_q.push_back(8'h60 + 8'(k));
         cyc();
      end
      for (int k = 0; k < 10; k++) begin
         drv_s(1'b1, 8'h62 + 8'(k), 1'b1, 1'b0);
         model_q.push_back(8'h62 + 8'(k));
         exp_d = model_q.pop_front();
         cyc();
         chk($sformatf("wrap[%0d].level", k), s_if.level_o, 2);
         chk($sformatf("wrap[%0d].rd_data", k), s_if.rd_data_o, exp_d);
         chk($sformatf("wrap[%0d].rd_vld", k), s_if.rd_vld_o, 1);
      end
      for (int k = 0; k < 2; k++) begin
         drv_s(1'b1, 8'h70 + 8'(k), 1'b0, 1'b0);
         model_q.push_back(8'h70 + 8'(k));
         cyc();
      end
      chk("full.wr_rdy", s_if.wr_rdy_o, 0);
      drv_s(1'b1, 8'h72, 1'b1, 1'b0);
      exp_d = model_q.pop_front();
      cyc();
      chk("full_wr_rd.level", s_if.level_o, 3);
      chk("full_wr_rd.ovf", s_if.ovf_o, 1);
      chk("full_wr_rd.rd_data", s_if.rd_data_o, exp_d);
      drv_s(1'b0, 8'h00, 1'b0, 1'b1);
      cyc();
      chk("full_wr_rd.clr", s_if.ovf_o, 0);
      for (int k = 0; k < 3; k++) begin
         drv_s(1'b0, 8'h00, 1'b1, 1'b0);
         exp_d = model_q.pop_front();
         cyc();
         chk($sformatf("tail[%0d].rd_data", k), s_if.rd_data_o, exp_d);
      end
      drv_s(1'b0, 8'h00, 1'b0, 1'b0);
      cyc();
      chk("tail.level", s_if.level_o, 0);

      // FWFT: fall-through, pop, capacity, overflow, back-to-back drain.
      drv_f(1'b1, 8'hA5, 1'b0, 1'b0);
      cyc();
      chk("fw.a5.rd_vld", f_if.rd_vld_o, 1);
      chk("fw.a5.rd_rdy", f_if.rd_rdy_o, 1);
      chk("fw.a5.rd_data", f_if.rd_data_o, 8'hA5);
      chk("fw.a5.level", f_if.level_o, 1);
      drv_f(1'b0, 8'h00, 1'b0, 1'b0);
      cyc();
      chk("fw.hold.rd_data", f_if.rd_data_o, 8'hA5);
      drv_f(1'b0, 8'h00, 1'b1, 1'b0);
      cyc();
      chk("fw.pop.rd_vld", f_if.rd_vld_o, 0);
      chk("fw.pop.level", f_if.level_o, 0);
      for (int k = 0; k < 4; k++) begin
         drv_f(1'b1, 8'hC1 + 8'(k), 1'b0, 1'b0);
         cyc();
         chk($sformatf("fw.fill[%0d].rd_data", k), f_if.rd_data_o, 8'hC1);
         chk($sformatf("fw.fill[%0d].level", k), f_if.level_o, 32'(k + 1));
      end
      chk("fw.full.wr_rdy", f_if.wr_rdy_o, 0);
      chk("fw.full.afull", f_if.almost_full_o, 1);
      drv_f(1'b1, 8'hC5, 1'b0, 1'b0);
      cyc();
      chk("fw.ovf", f_if.ovf_o, 1);
      chk("fw.ovf.level", f_if.level_o, 4);
      for (int k = 0; k < 3; k++) begin
         drv_f(1'b0, 8'h00, 1'b1, 1'b0);
         cyc();
         chk($sformatf("fw.drain[%0d].rd_data", k), f_if.rd_data_o, 8'hC2 + 8'(k));
         chk($sformatf("fw.drain[%0d].level", k), f_if.level_o, 32'(3 - k));
      end
      cyc();
      chk("fw.drain.last_vld", f_if.rd_vld_o, 0);
      chk("fw.drain.udf_clean", f_if.udf_o, 0);
      cyc();
      chk("fw.udf", f_if.udf_o, 1);
      drv_f(1'b1, 8'hD1, 1'b1, 1'b0);
      cyc();
      chk("fw.empty_wr_rd.level", f_if.level_o, 1);
      chk("fw.empty_wr_rd.rd_data", f_if.rd_data_o, 8'hD1);
      drv_f(1'b1, 8'hD2, 1'b1, 1'b0);
      cyc();
      chk("fw.pop_wr.level", f_if.level_o, 1);
      chk("fw.pop_wr.rd_data", f_if.rd_data_o, 8'hD2);
      drv_f(1'b0, 8'h00, 1'b0, 1'b0);

      // Asynchronous reset between edges at level 3.
      for (int k = 0; k < 3; k++) begin
         drv_s(1'b1, 8'h31 + 8'(k), 1'b0, 1'b0);
         cyc();
      end
      drv_s(1'b0, 8'h00, 1'b0, 1'b0);
      chk("arst.pre.level", s_if.level_o, 3);
      #2 rst = 1'b1;
      #1;
      chk("arst.level", s_if.level_o, 0);
      chk("arst.wr_rdy", s_if.wr_rdy_o, 1);
      chk("arst.rd_rdy", s_if.rd_rdy_o, 0);
      chk("arst.aempty", s_if.almost_empty_o, 1);
      chk("arst.rd_data", s_if.rd_data_o, 0);
      chk("arst.fwft.rd_vld", f_if.rd_vld_o, 0);
      cyc();
      rst = 1'b0;
      drv_s(1'b1, 8'h5A, 1'b0, 1'b0);
      cyc();
      drv_s(1'b0, 8'h00, 1'b1, 1'b0);
      cyc();
      chk("arst.post.rd_data", s_if.rd_data_o, 8'h5A);
      chk("arst.post.level", s_if.level_o, 0);
      drv_s(1'b0, 8'h00, 1'b0, 1'b0);
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
